alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares a single alu4bit instance between two requesters.
//  - Arbitrates operand/opcode requests round-robin.
//  - Drives the ALU a/b/sel inputs from registered operands and waits a fixed ALU latency.
//  - Captures z and returns it with the winning requester's ID over a valid/ready response channel.
//  - Sits between the instruction-side producers and the ALU datapath. One operation in flight at a time.
// PARAMETERS
//  OPW      9   operand width (ALU a/b)
//  SELW     4   opcode width (ALU sel)
//  RESW     32  result width (ALU z)
//  ALU_LAT  0   extra cycles z needs after a/b/sel settle (0 = combinational ALU); legal range 0..15
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst_n       in   1     asynchronous active-low reset
//  req0_valid  in   1     requester 0 has an op
//  req0_ready  out  1     requester 0 op accepted this cycle when valid&ready
//  req0_a      in   OPW   requester 0 operand a
//  req0_b      in   OPW   requester 0 operand b
//  req0_sel    in   SELW  requester 0 opcode
//  req1_valid  in   1     requester 1 has an op
//  req1_ready  out  1     requester 1 accept
//  req1_a      in   OPW   requester 1 operand a
//  req1_b      in   OPW   requester 1 operand b
//  req1_sel    in   SELW  requester 1 opcode
//  alu_a       out  OPW   to ALU a (registered)
//  alu_b       out  OPW   to ALU b (registered)
//  alu_sel     out  SELW  to ALU sel (registered)
//  alu_z       in   RESW  from ALU z
//  rsp_valid   out  1     result available
//  rsp_ready   in   1     consumer takes result when valid&ready
//  rsp_z       out  RESW  captured result
//  rsp_id      out  1     requester that issued the op
//  busy        out  1     high in EXEC or DONE
// BEHAVIOUR
//  Reset
//  - rst_n low: FSM=IDLE, cnt=0, last_grant=1 (req0 wins first).
//  - alu_a/alu_b/alu_sel/rsp_z=0, rsp_id=0, rsp_valid=0, busy=0.
//  - Asserting rst_n mid-operation aborts the op; the result is discarded.
//  FSM
//  - IDLE->EXEC on accept; EXEC->DONE when cnt==ALU_LAT; DONE->IDLE on rsp_valid&rsp_ready.
//  Grant (IDLE only, combinational)
//  - Only one valid: grant it.
//  - Both valid: grant !last_grant.
//  - reqN_ready = (state==IDLE) & reqN_valid & grant==N.
//  - Readies are 0 outside IDLE. At most one ready per cycle.
//  Accept
//  - Latch the granted a/b/sel into alu_a/alu_b/alu_sel, latch ID into rsp_id.
//  - last_grant<=ID, cnt<=0.
//  EXEC
//  - cnt increments each cycle.
//  - When cnt==ALU_LAT: rsp_z<=alu_z, rsp_valid<=1.
//  - EXEC lasts ALU_LAT+1 cycles.
//  Latency and throughput
//  - Accept at edge T -> rsp_valid high from edge T+2+ALU_LAT.
//  - Peak throughput: one op per ALU_LAT+3 cycles.
//  - No accept in the same cycle as the DONE handshake; IDLE is always visited.
//  Hold rules
//  - alu_a/b/sel hold their last value until the next accept (never return to 0 except on reset).
//  - In DONE, rsp_z/rsp_id/rsp_valid stay stable until rsp_ready.
//  Arithmetic
//  - No arithmetic on data; values pass through unchanged. sel is not decoded (4'b1111 passes as-is).
//  - rsp_z takes the full RESW bits of alu_z.
// TESTING
//  T1 Reset: rst_n=0 with both valids high -> all outputs 0, both readies 0. Release -> req0_ready=1 first.
//  T2 Single op: req0 a=1,b=0,sel=4'b0000, ALU stub z=32'h0000_005A, ALU_LAT=0.
//     -> alu_a=1 at T+1; rsp_valid at T+2 with rsp_z=32'h5A, rsp_id=0.
//  T3 Contention: both valids held high for 6 ops (req1 a=0,b=1,sel=4'b0010) -> rsp_id sequence 0,1,0,1,0,1.
//  T4 Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid/z/id constant, readies 0, busy=1.
//     Then rsp_ready=1 -> IDLE next cycle.
//  T5 ALU_LAT=3: op accepted at T, stub changes z at T+3 to 32'hDEAD_BEEF
//     -> rsp_valid at T+5, rsp_z=32'hDEAD_BEEF.
//  T6 Reset in EXEC (ALU_LAT=3, cnt=1) -> rsp_valid never rises for that op.
//     Next req1 op completes normally; with both valid after reset, req0 granted first.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one op in flight.
// Latency: accept -> rsp_valid after ALU_LAT+2 cycles; readies low outside IDLE, DONE holds until rsp_ready.
// Backpressure: rsp_ready low freezes the result in DONE and blocks new accepts.
module alu_req_arbiter #(
    parameter int OPW     = 9,
    parameter int SELW    = 4,
    parameter int RESW    = 32,
    parameter int ALU_LAT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [OPW-1:0]  req0_a,
    input  logic [OPW-1:0]  req0_b,
    input  logic [SELW-1:0] req0_sel,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [OPW-1:0]  req1_a,
    input  logic [OPW-1:0]  req1_b,
    input  logic [SELW-1:0] req1_sel,
    output logic [OPW-1:0]  alu_a,
    output logic [OPW-1:0]  alu_b,
    output logic [SELW-1:0] alu_sel,
    input  logic [RESW-1:0] alu_z,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [RESW-1:0] rsp_z,
    output logic            rsp_id,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       last_grant;
    logic       grant;
    logic       accept;
    logic       lat_hit;
    logic       rsp_fire;

    // Fair pick when both ask: whoever did not win last time.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Gated by rst_n so nothing looks accepted while the block is held in reset.
    assign req0_ready = rst_n & (state == IDLE) & req0_valid & ~grant;
    assign req1_ready = rst_n & (state == IDLE) & req1_valid & grant;
    assign accept     = req0_ready | req1_ready;
    assign lat_hit    = (cnt == LAT);
    assign rsp_fire   = rsp_valid & rsp_ready;
    assign busy       = (state == EXEC) || (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)   state_nxt = EXEC;
            EXEC: if (lat_hit)  state_nxt = DONE;
            DONE: if (rsp_fire) state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_z      <= '0;
            rsp_id     <= 1'b0;
            rsp_valid  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a      <= grant ? req1_a   : req0_a;
                alu_b      <= grant ? req1_b   : req0_b;
                alu_sel    <= grant ? req1_sel : req0_sel;
                rsp_id     <= grant;
                last_grant <= grant;
                cnt        <= 4'd0;
            end
            if (state == EXEC) begin
                cnt <= cnt + 4'd1;
                // alu_z has had ALU_LAT extra cycles to settle on the registered operands.
                if (lat_hit) begin
                    rsp_z     <= alu_z;
                    rsp_valid <= 1'b1;
                end
            end
            if ((state == DONE) && rsp_fire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench: d0 (ALU_LAT=0, functional ALU stub) and d3 (ALU_LAT=3, bench-driven z).
module tb_alu_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ALU_LAT=0 instance
    logic        d0_rst_n, d0_req0_valid, d0_req0_ready, d0_req1_valid, d0_req1_ready;
    logic [8:0]  d0_req0_a, d0_req0_b, d0_req1_a, d0_req1_b, d0_alu_a, d0_alu_b;
    logic [3:0]  d0_req0_sel, d0_req1_sel, d0_alu_sel;
    logic [31:0] d0_alu_z, d0_rsp_z;
    logic        d0_rsp_valid, d0_rsp_ready, d0_rsp_id, d0_busy;

    // ALU_LAT=3 instance
    logic        d3_rst_n, d3_req0_valid, d3_req0_ready, d3_req1_valid, d3_req1_ready;
    logic [8:0]  d3_req0_a, d3_req0_b, d3_req1_a, d3_req1_b, d3_alu_a, d3_alu_b;
    logic [3:0]  d3_req0_sel, d3_req1_sel, d3_alu_sel;
    logic [31:0] d3_alu_z, d3_rsp_z;
    logic        d3_rsp_valid, d3_rsp_ready, d3_rsp_id, d3_busy;

    // Combinational ALU stand-in: the T2 vector yields 5A, anything else packs the inputs.
    function automatic logic [31:0] stub0(input logic [8:0] a, input logic [8:0] b, input logic [3:0] s);
        if (a == 9'd1 && b == 9'd0 && s == 4'd0) return 32'h0000_005A;
        return {10'h0, s, b, a};
    endfunction

    assign d0_alu_z = stub0(d0_alu_a, d0_alu_b, d0_alu_sel);

    alu_req_arbiter #(.OPW(9), .SELW(4), .RESW(32), .ALU_LAT(0)) u_d0 (
        .clk(clk), .rst_n(d0_rst_n),
        .req0_valid(d0_req0_valid), .req0_ready(d0_req0_ready),
        .req0_a(d0_req0_a), .req0_b(d0_req0_b), .req0_sel(d0_req0_sel),
        .req1_valid(d0_req1_valid), .req1_ready(d0_req1_ready),
        .req1_a(d0_req1_a), .req1_b(d0_req1_b), .req1_sel(d0_req1_sel),
        .alu_a(d0_alu_a), .alu_b(d0_alu_b), .alu_sel(d0_alu_sel), .alu_z(d0_alu_z),
        .rsp_valid(d0_rsp_valid), .rsp_ready(d0_rsp_ready),
        .rsp_z(d0_rsp_z), .rsp_id(d0_rsp_id), .busy(d0_busy)
    );

    alu_req_arbiter #(.OPW(9), .SELW(4), .RESW(32), .ALU_LAT(3)) u_d3 (
        .clk(clk), .rst_n(d3_rst_n),
        .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready),
        .req0_a(d3_req0_a), .req0_b(d3_req0_b), .req0_sel(d3_req0_sel),
        .req1_valid(d3_req1_valid), .req1_ready(d3_req1_ready),
        .req1_a(d3_req1_a), .req1_b(d3_req1_b), .req1_sel(d3_req1_sel),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_sel(d3_alu_sel), .alu_z(d3_alu_z),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready),
        .rsp_z(d3_rsp_z), .rsp_id(d3_rsp_id), .busy(d3_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrsp, last_cyc, onehot_bad, gap_bad, bad;

        d0_rst_n = 1'b0; d3_rst_n = 1'b0;
        d0_req0_valid = 1'b1; d0_req0_a = 9'd1; d0_req0_b = 9'd0; d0_req0_sel = 4'b0000;
        d0_req1_valid = 1'b1; d0_req1_a = 9'd0; d0_req1_b = 9'd1; d0_req1_sel = 4'b0010;
        d0_rsp_ready  = 1'b0;
        d3_req0_valid = 1'b0; d3_req0_a = 9'd0; d3_req0_b = 9'd0; d3_req0_sel = 4'd0;
        d3_req1_valid = 1'b0; d3_req1_a = 9'd0; d3_req1_b = 9'd0; d3_req1_sel = 4'd0;
        d3_rsp_ready  = 1'b1; d3_alu_z = 32'h0;

        // T1: reset with both valids high
        tick(); tick();
        chk("t1_ready0", d0_req0_ready, 0);
        chk("t1_ready1", d0_req1_ready, 0);
        chk("t1_alu_a", d0_alu_a, 0);
        chk("t1_alu_b", d0_alu_b, 0);
        chk("t1_alu_sel", d0_alu_sel, 0);
        chk("t1_rsp_valid", d0_rsp_valid, 0);
        chk("t1_rsp_z", d0_rsp_z, 0);
        chk("t1_rsp_id", d0_rsp_id, 0);
        chk("t1_busy", d0_busy, 0);
        d0_rst_n = 1'b1;
        #1;
        chk("t1_first_ready0", d0_req0_ready, 1);
        chk("t1_first_ready1", d0_req1_ready, 0);

        // T2: single req0 op
        d0_req1_valid = 1'b0;
        tick();
        chk("t2_alu_a", d0_alu_a, 1);
        chk("t2_alu_b", d0_alu_b, 0);
        chk("t2_alu_sel", d0_alu_sel, 0);
        chk("t2_busy_exec", d0_busy, 1);
        chk("t2_ready0_exec", d0_req0_ready, 0);
        chk("t2_rsp_valid_early", d0_rsp_valid, 0);
        d0_req0_valid = 1'b0; d0_rsp_ready = 1'b1;
        tick();
        chk("t2_rsp_valid", d0_rsp_valid, 1);
        chk("t2_rsp_z", d0_rsp_z, 32'h0000_005A);
        chk("t2_rsp_id", d0_rsp_id, 0);
        tick();
        chk("t2_rsp_valid_drop", d0_rsp_valid, 0);
        chk("t2_busy_idle", d0_busy, 0);
        chk("t2_alu_a_hold", d0_alu_a, 1);

        // T3: contention from a fresh reset, six ops
        d0_rst_n = 1'b0;
        tick();
        d0_rst_n = 1'b1;
        d0_req0_valid = 1'b1; d0_req1_valid = 1'b1;
        nrsp = 0; last_cyc = 0; onehot_bad = 0; gap_bad = 0;
        for (int c = 0; c < 60 && nrsp < 6; c++) begin
            tick();
            if (d0_req0_ready && d0_req1_ready) onehot_bad++;
            if (d0_rsp_valid) begin
                chk("t3_rsp_id", d0_rsp_id, nrsp % 2);
                chk("t3_rsp_z", d0_rsp_z, (nrsp % 2 == 1) ? 32'h0008_0200 : 32'h0000_005A);
                if (nrsp > 0 && (c - last_cyc) != 3) gap_bad++;
                last_cyc = c;
                nrsp++;
            end
        end
        d0_req0_valid = 1'b0; d0_req1_valid = 1'b0;
        chk("t3_rsp_count", nrsp, 6);
        chk("t3_two_readies", onehot_bad, 0);
        chk("t3_op_spacing", gap_bad, 0);
        tick();

        // T4: backpressure in DONE; sel=4'b1111 passes through
        d0_req0_a = 9'd3; d0_req0_b = 9'd4; d0_req0_sel = 4'b1111;
        d0_req0_valid = 1'b1; d0_rsp_ready = 1'b0;
        #1;
        chk("t4_ready0", d0_req0_ready, 1);
        tick();
        d0_req0_valid = 1'b0; d0_req1_valid = 1'b1;
        chk("t4_alu_sel", d0_alu_sel, 4'b1111);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_rsp_valid", d0_rsp_valid, 1);
            chk("t4_rsp_z", d0_rsp_z, 32'h003C_0803);
            chk("t4_rsp_id", d0_rsp_id, 0);
            chk("t4_ready1", d0_req1_ready, 0);
            chk("t4_busy", d0_busy, 1);
            tick();
        end
        d0_rsp_ready = 1'b1; d0_req0_valid = 1'b1;
        tick();
        chk("t4_busy_idle", d0_busy, 0);
        chk("t4_rsp_valid_drop", d0_rsp_valid, 0);
        chk("t4_rr_ready1", d0_req1_ready, 1);
        chk("t4_rr_ready0", d0_req0_ready, 0);
        chk("t4_alu_a_hold", d0_alu_a, 3);
        d0_req0_valid = 1'b0; d0_req1_valid = 1'b0;

        // T5: ALU_LAT=3, z changes three cycles after the accept cycle
        d3_rst_n = 1'b1;
        d3_req0_a = 9'd5; d3_req0_b = 9'd6; d3_req0_sel = 4'd1; d3_req0_valid = 1'b1;
        #1;
        chk("t5_ready0", d3_req0_ready, 1);
        tick();
        d3_req0_valid = 1'b0;
        chk("t5_alu_a", d3_alu_a, 5);
        chk("t5_busy", d3_busy, 1);
        tick();
        chk("t5_rsp_valid_e2", d3_rsp_valid, 0);
        tick();
        d3_alu_z = 32'hDEAD_BEEF;
        chk("t5_rsp_valid_e3", d3_rsp_valid, 0);
        tick();
        chk("t5_rsp_valid_e4", d3_rsp_valid, 0);
        tick();
        chk("t5_rsp_valid", d3_rsp_valid, 1);
        chk("t5_rsp_z", d3_rsp_z, 32'hDEAD_BEEF);
        chk("t5_rsp_id", d3_rsp_id, 0);
        tick();
        chk("t5_busy_idle", d3_busy, 0);

        // T6: reset during EXEC at cnt=1 aborts the op
        d3_alu_z = 32'h0000_1234;
        d3_req1_a = 9'd7; d3_req1_b = 9'd8; d3_req1_sel = 4'd3; d3_req1_valid = 1'b1;
        #1;
        chk("t6_ready1", d3_req1_ready, 1);
        tick();
        d3_req1_valid = 1'b0;
        tick();
        d3_rst_n = 1'b0;
        #1;
        chk("t6_rst_rsp_valid", d3_rsp_valid, 0);
        chk("t6_rst_busy", d3_busy, 0);
        chk("t6_rst_alu_a", d3_alu_a, 0);
        tick();
        d3_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (d3_rsp_valid) bad++;
        end
        chk("t6_aborted_no_rsp", bad, 0);
        d3_req0_a = 9'd2; d3_req0_valid = 1'b1;
        d3_req1_a = 9'd9; d3_req1_b = 9'd10; d3_req1_sel = 4'd4; d3_req1_valid = 1'b1;
        #1;
        chk("t6_post_rst_ready0", d3_req0_ready, 1);
        chk("t6_post_rst_ready1", d3_req1_ready, 0);
        d3_req0_valid = 1'b0;
        #1;
        chk("t6_solo_ready1", d3_req1_ready, 1);
        tick();
        d3_req1_valid = 1'b0;
        d3_alu_z = 32'hCAFE_0001;
        for (int k = 0; k < 20 && !d3_rsp_valid; k++) tick();
        chk("t6_rsp_valid", d3_rsp_valid, 1);
        chk("t6_rsp_z", d3_rsp_z, 32'hCAFE_0001);
        chk("t6_rsp_id", d3_rsp_id, 1);
        chk("t6_alu_a", d3_alu_a, 9);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
